pipe_addsub: RTL

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub_if.sv | 27 ++
 rtl/pipe_addsub.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// The master drives operands and consumes results; the slave is the adder pipeline.
interface pipe_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             in_sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_ovf;
   logic             out_carry;

   modport master (
      output in_valid, in_a, in_b, in_sub, in_sat, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_carry
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, in_sat, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_carry
   );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract with a segmented carry chain: slice k of the sum is
// resolved in stage k, with elastic valid/ready slot advance and optional saturation.
module pipe_addsub_stage #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int K      = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_i,
   input  logic             vld_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] res_i,
   input  logic             cy_i,
   input  logic             sat_i,
   output logic             vld_o,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [WIDTH-1:0] res_o,
   output logic             cy_o,
   output logic             sat_o,
   output logic             ovf_o
);
   localparam int SW   = WIDTH / STAGES;
   localparam bit LAST = (K == STAGES - 1);

   logic [SW:0]      slice;
   logic [WIDTH-1:0] res_d;
   logic             cy_d;
   logic             ovf_d;

   logic             vld_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             cy_q;
   logic             sat_q;
   logic             ovf_q;

   // Slices above K are still zero in res_i, so OR-ing the new slice in is enough.
   always_comb begin
      slice = {1'b0, a_i[K*SW +: SW]} + {1'b0, b_i[K*SW +: SW]} + {{SW{1'b0}}, cy_i};
      res_d = res_i | (WIDTH'(slice[SW-1:0]) << (K*SW));
      cy_d  = slice[SW];
      ovf_d = 1'b0;
      if (LAST) begin
         ovf_d = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res_d[WIDTH-1] != a_i[WIDTH-1]);
         if (sat_i && ovf_d)
            res_d = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         cy_q  <= 1'b0;
         sat_q <= 1'b0;
         ovf_q <= 1'b0;
      end else if (ld_i) begin
         vld_q <= vld_i;
         if (vld_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            res_q <= res_d;
            cy_q  <= cy_d;
            sat_q <= sat_i;
            ovf_q <= ovf_d;
         end
      end
   end

   assign vld_o = vld_q;
   assign a_o   = a_q;
   assign b_o   = b_q;
   assign res_o = res_q;
   assign cy_o  = cy_q;
   assign sat_o = sat_q;
   assign ovf_o = ovf_q;
endmodule

module pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   pipe_addsub_if.slave bus
);
   // Index 0 is the input side; index k+1 is the register output of stage k.
   logic [STAGES:0]            vld_w;
   logic [STAGES:0]            cy_w;
   logic [STAGES:0]            sat_w;
   logic [STAGES:0]            rdy;
   logic [STAGES:0][WIDTH-1:0] a_w;
   logic [STAGES:0][WIDTH-1:0] b_w;
   logic [STAGES:0][WIDTH-1:0] res_w;
   logic [STAGES-1:0]          ovf_w;
   logic                       unused_tail;

   // Subtract is A + ~B + 1: invert B up front and feed the +1 as carry-in.
   assign vld_w[0] = bus.in_valid;
   assign a_w[0]   = bus.in_a;
   assign b_w[0]   = bus.in_sub ? ~bus.in_b : bus.in_b;
   assign res_w[0] = '0;
   assign cy_w[0]  = bus.in_sub;
   assign sat_w[0] = bus.in_sat;

   // rdy[k] is the load enable of stage k; an empty stage always loads.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--)
         rdy[k] = !vld_w[k+1] || rdy[k+1];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_addsub_stage #(
         .WIDTH  (WIDTH),
         .STAGES (STAGES),
         .K      (k)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .ld_i  (rdy[k]),
         .vld_i (vld_w[k]),
         .a_i   (a_w[k]),
         .b_i   (b_w[k]),
         .res_i (res_w[k]),
         .cy_i  (cy_w[k]),
         .sat_i (sat_w[k]),
         .vld_o (vld_w[k+1]),
         .a_o   (a_w[k+1]),
         .b_o   (b_w[k+1]),
         .res_o (res_w[k+1]),
         .cy_o  (cy_w[k+1]),
         .sat_o (sat_w[k+1]),
         .ovf_o (ovf_w[k])
      );
   end

   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = vld_w[STAGES];
   assign bus.out_sum   = res_w[STAGES];
   assign bus.out_carry = cy_w[STAGES];
   assign bus.out_ovf   = ovf_w[STAGES-1];

   assign unused_tail = ^{a_w[STAGES], b_w[STAGES], sat_w[STAGES], ovf_w};
endmodule
